piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: parallel word width in bits (supported range 2..32).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RESETN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port DATA_IN  input  WIDTH  parallel word to transmit.
REQ-005 SHALL have port LOAD_VALID  input  1  DATA_IN holds a valid word.
REQ-006 SHALL have port LOAD_READY  output  1  block can accept a word this cycle.
REQ-007 SHALL have port SER_OUT  output  1  serial data bit.
REQ-008 SHALL have port SER_VALID  output  1  SER_OUT carries a frame bit this cycle.
REQ-009 SHALL have port FRAME_START  output  1  high during the first bit of each frame.
REQ-010 SHALL have port DONE  output  1  high during the last bit of each frame.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and SHIFT (plus PARITY when PISO_PARITY_EN is defined).
REQ-012 SHALL accept a word when LOAD_VALID and LOAD_READY are both high at a rising CLK edge; DATA_IN is captured into an internal WIDTH-bit shift register.
REQ-013 SHALL drive LOAD_READY high in IDLE and during the final frame-bit cycle; low otherwise.
REQ-014 SHALL, one cycle after acceptance, enter SHIFT with SER_VALID=1, FRAME_START=1, SER_OUT=DATA_IN[WIDTH-1] (MSB first).
REQ-015 SHALL present bit WIDTH-1-k on SER_OUT in the k-th SHIFT cycle (k=0..WIDTH-1), with exactly WIDTH consecutive SER_VALID cycles per frame and no gaps.
REQ-016 SHALL hold FRAME_START high only in the k=0 cycle and DONE high only in the final frame-bit cycle; for WIDTH>=2 the two never coincide.
REQ-017 SHALL use a bit counter of ceil(log2(WIDTH+1)) bits that is cleared on acceptance and wraps to 0 at frame end, never exceeding the frame length.
REQ-018 SHALL, if a word is accepted in the final frame-bit cycle, start the next frame on the following cycle (back-to-back, zero idle cycles); otherwise return to IDLE.
REQ-019 SHALL ignore LOAD_VALID and DATA_IN in all SHIFT cycles except the final one; DATA_IN changes mid-frame do not affect the frame in flight.
REQ-020 SHALL drive SER_OUT=0, SER_VALID=0, FRAME_START=0, DONE=0 in IDLE.
REQ-021 SHALL guarantee that SER_OUT, shifted into a WIDTH-bit LSB-insert serial-in/parallel-out register on the same CLK and enabled by SER_VALID, reproduces the transmitted word after the DONE cycle.

Reset
REQ-022 SHALL, on RESETN low, immediately force FSM=IDLE, counter=0, shift register=0, SER_OUT=0, SER_VALID=0, FRAME_START=0, DONE=0, LOAD_READY=0.
REQ-023 SHALL abort any frame in flight on reset with no resumption; the partial frame is discarded.
REQ-024 SHALL raise LOAD_READY on the first rising CLK edge after RESETN deasserts, and accept no word on that edge.

Configuration
REQ-025 SHALL, when macro PISO_PARITY_EN is defined, append one even-parity bit (XOR of all WIDTH data bits) in a PARITY state after the LSB, making frames WIDTH+1 bits, with DONE and the LOAD_READY window moved to the parity cycle.
REQ-026 SHALL, when PISO_PARITY_EN is undefined, omit the PARITY state and logic entirely, giving WIDTH-bit frames.

Verification
REQ-027 Reset then idle: RESETN low for 3 cycles -> all outputs 0; after release, LOAD_READY=1 from the next edge with SER_VALID=0.
REQ-028 Single frame: load 16'hA5C3 -> SER_OUT sequence 1010010111000011 over 16 cycles, FRAME_START on the 1st bit, DONE on the 16th, then IDLE.
REQ-029 Back-to-back: hold LOAD_VALID high with 16'hFFFF then 16'h0001 -> 32 contiguous SER_VALID cycles, LOAD_READY high only in the idle cycle and in cycle 16.
REQ-030 Mid-frame abort: load 16'h8001, pull RESETN low after bit 7 -> outputs 0 immediately; next load of 16'h00FF transmits cleanly from its MSB.
REQ-031 Loopback: serializer driving a 16-bit serial-in/parallel-out register, 100 random words -> the register equals each word on the cycle after DONE.
REQ-032 Parity build (PISO_PARITY_EN): load 16'h0007 -> 17-bit frame ending in parity bit 1, DONE on the 17th bit; load 16'h0003 -> parity bit 0.

Source files
------------

// File: rtl/piso_serializer.sv
// MSB-first parallel-to-serial shifter: word accepted on load_valid&&load_ready, first bit one cycle later, back-to-back on the last bit.
// load_ready is high in IDLE and on the final frame bit; define PISO_PARITY_EN to append an even-parity bit to each frame.
module piso_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             rdy_en;
  logic             accept;
  logic             last_bit;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  assign accept   = load_valid && load_ready;
  assign last_bit = (state == SHIFT) && (cnt == LAST);

  // rdy_en keeps load_ready low through the first edge after reset release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      shreg  <= '0;
      rdy_en <= 1'b0;
`ifdef PISO_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
      if (accept) begin
        shreg <= data_in;
        cnt   <= '0;
`ifdef PISO_PARITY_EN
        par   <= ^data_in;
`endif
      end else if (state == SHIFT) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
        cnt   <= last_bit ? '0 : cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
      SHIFT: begin
        if (last_bit) begin
`ifdef PISO_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: state_nxt = accept ? SHIFT : IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ready  = 1'b0;
    ser_out     = 1'b0;
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: load_ready = rdy_en;
      SHIFT: begin
        ser_valid   = 1'b1;
        ser_out     = shreg[WIDTH-1];
        frame_start = (cnt == '0);
`ifndef PISO_PARITY_EN
        done        = last_bit;
        load_ready  = last_bit;
`endif
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        ser_valid  = 1'b1;
        ser_out    = par;
        done       = 1'b1;
        load_ready = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (WIDTH=16); inputs driven and outputs sampled on the falling edge.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FLEN = 17;
`else
  localparam int FLEN = 16;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] data_in;
  logic        load_valid;
  logic        load_ready, ser_out, ser_valid, frame_start, done;
  logic [15:0] sipo = '0;
  int          checks = 0;
  int          fails  = 0;

  piso_serializer #(.WIDTH(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .frame_start(frame_start),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ser_valid) sipo <= {sipo[14:0], ser_out};

  // Observation vector: {ser_valid, ser_out, frame_start, done, load_ready}
  wire [4:0] obs = {ser_valid, ser_out, frame_start, done, load_ready};

  // Starts at a falling edge in IDLE; checks every frame bit and the idle cycle after.
  task automatic run_frame(input logic [15:0] w, input logic p, input logic scramble, input string name);
    logic [4:0] exp;
    logic       b;
    checks++;
    if (obs !== 5'b00001) begin fails++; $display("FAIL %s pre-idle: got %b want 00001", name, obs); end
    data_in    = w;
    load_valid = 1'b1;
    for (int k = 0; k < FLEN; k++) begin
      @(negedge clk);
      b   = (k < 16) ? w[15-k] : p;
      exp = {1'b1, b, k == 0, k == FLEN-1, k == FLEN-1};
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL %s bit%0d: got %b want %b", name, k, obs, exp); end
      if (scramble && k < FLEN-1) begin
        data_in    = 16'($urandom);
        load_valid = 1'b1;
      end else begin
        load_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (obs !== 5'b00001) begin fails++; $display("FAIL %s post-idle: got %b want 00001", name, obs); end
  endtask

  task automatic test_reset();
    resetn     = 1'b0;
    load_valid = 1'b0;
    data_in    = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 5'b00000) begin fails++; $display("FAIL reset_outs: got %b want 00000", obs); end
    data_in    = 16'h1234;
    load_valid = 1'b1;
    resetn     = 1'b1;
    #1;
    checks++;
    if (load_ready !== 1'b0) begin fails++; $display("FAIL release_ready: got %b want 0", load_ready); end
    @(negedge clk);
    checks++;
    if (obs !== 5'b00001) begin fails++; $display("FAIL first_edge: got %b want 00001", obs); end
    load_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 5'b00001) begin fails++; $display("FAIL no_accept_first_edge: got %b want 00001", obs); end
  endtask

  task automatic test_single();
    run_frame(16'hA5C3, 1'b0, 1'b1, "single_a5c3");
  endtask

  task automatic test_back_to_back();
    logic [4:0]  exp;
    logic [15:0] w;
    logic        b;
    int          k;
    checks++;
    if (obs !== 5'b00001) begin fails++; $display("FAIL b2b idle: got %b want 00001", obs); end
    data_in    = 16'hFFFF;
    load_valid = 1'b1;
    for (int j = 0; j < 2*FLEN; j++) begin
      @(negedge clk);
      k   = j % FLEN;
      w   = (j < FLEN) ? 16'hFFFF : 16'h0001;
      b   = (k < 16) ? w[15-k] : (j >= FLEN);
      exp = {1'b1, b, k == 0, k == FLEN-1, k == FLEN-1};
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL b2b cyc%0d: got %b want %b", j, obs, exp); end
      if (j == FLEN-1) data_in = 16'h0001;
      if (j >= FLEN) load_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (obs !== 5'b00001) begin fails++; $display("FAIL b2b end: got %b want 00001", obs); end
  endtask

  task automatic test_abort();
    logic [4:0]  exp;
    logic [15:0] w;
    w          = 16'h8001;
    data_in    = w;
    load_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      load_valid = 1'b0;
      exp = {1'b1, w[15-k], k == 0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL abort bit%0d: got %b want %b", k, obs, exp); end
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (obs !== 5'b00000) begin fails++; $display("FAIL abort async: got %b want 00000", obs); end
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 5'b00000) begin fails++; $display("FAIL abort held: got %b want 00000", obs); end
    resetn = 1'b1;
    @(negedge clk);
    run_frame(16'h00FF, 1'b0, 1'b0, "after_abort_00ff");
  endtask

  task automatic test_loopback();
    logic [15:0] cur, nxt;
    int          n;
    cur        = 16'($urandom);
    data_in    = cur;
    load_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      load_valid = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) begin
        checks++;
        fails++;
        $display("FAIL loopback timeout word%0d: got no done want done", i);
        break;
      end
      nxt = 16'($urandom);
      if (i < 99) begin
        data_in    = nxt;
        load_valid = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (sipo !== cur) begin fails++; $display("FAIL loopback word%0d: got %h want %h", i, sipo, cur); end
      cur = nxt;
    end
    load_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    run_frame(16'h0007, 1'b1, 1'b0, "parity_0007");
    run_frame(16'h0003, 1'b0, 1'b0, "parity_0003");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
`ifdef PISO_PARITY_EN
    test_parity();
`else
    test_loopback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
